seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Four-digit multiplexed 7-segment scanner with guard-band blanking
//            and frame-synchronous double-buffered display value.
// Options  : LEADING_ZERO_BLANK_EN - blank leading zero digits 3..1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl #(
    parameter int PRESCALAR = 1000,
    parameter int GUARD     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  sel,
    output logic        frame_done,
    output logic        pending
);

    localparam int               c_CNT_W      = $clog2(PRESCALAR);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(PRESCALAR - 1);
    localparam logic [c_CNT_W-1:0] c_GUARD_LAST = c_CNT_W'(GUARD - 1);

    typedef enum logic [0:0] {
        ST_GUARD = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [1:0]           r_sel;
    logic [15:0]          r_staging;
    logic [3:0]           r_staging_dp;
    logic [15:0]          r_shadow;
    logic [3:0]           r_shadow_dp;
    logic                 r_pending;
    logic [3:0]           r_an;
    logic [6:0]           r_seg;
    logic                 r_dp;
    logic                 r_frame_done;

    logic                 w_cnt_last;
    logic                 w_boundary;
    logic [c_CNT_W-1:0]   w_cnt_nx;
    logic [1:0]           w_sel_nx;
    state_t               w_state_nx;
    logic [15:0]          w_shadow_nx;
    logic [3:0]           w_shadow_dp_nx;
    logic [3:0]           w_digit;
    logic [3:0]           w_blank;
    logic [6:0]           w_seg_nx;
    logic [3:0]           w_an_nx;
    logic                 w_dp_nx;
    logic                 w_frame_done_nx;

    assign w_cnt_last = (r_cnt == c_CNT_LAST);
    assign w_boundary = w_cnt_last && (r_sel == 2'd3);
    assign w_cnt_nx   = w_cnt_last ? '0 : r_cnt + c_CNT_W'(1);
    assign w_sel_nx   = w_cnt_last ? r_sel + 2'd1 : r_sel;

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_GUARD: if (r_cnt == c_GUARD_LAST) w_state_nx = ST_ON;
            ST_ON:    if (w_cnt_last)            w_state_nx = ST_GUARD;
            default:  w_state_nx = ST_GUARD;
        endcase
    end

    // A load on the boundary cycle bypasses staging so it is not lost.
    always_comb begin
        w_shadow_nx    = r_shadow;
        w_shadow_dp_nx = r_shadow_dp;
        if (w_boundary && load) begin
            w_shadow_nx    = bcd_in;
            w_shadow_dp_nx = dp_in;
        end else if (w_boundary && r_pending) begin
            w_shadow_nx    = r_staging;
            w_shadow_dp_nx = r_staging_dp;
        end
    end

    always_comb begin
        w_digit = w_shadow_nx[3:0];
        case (w_sel_nx)
            2'd0: w_digit = w_shadow_nx[3:0];
            2'd1: w_digit = w_shadow_nx[7:4];
            2'd2: w_digit = w_shadow_nx[11:8];
            2'd3: w_digit = w_shadow_nx[15:12];
            default: w_digit = w_shadow_nx[3:0];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        w_blank    = 4'b0000;
        w_blank[3] = (w_shadow_nx[15:12] == 4'd0);
        w_blank[2] = w_blank[3] && (w_shadow_nx[11:8] == 4'd0);
        w_blank[1] = w_blank[2] && (w_shadow_nx[7:4] == 4'd0);
    end
`else
    assign w_blank = 4'b0000;
`endif

    always_comb begin
        w_seg_nx = 7'b0111111;
        case (w_digit)
            4'd0: w_seg_nx = 7'b1000000;
            4'd1: w_seg_nx = 7'b1111001;
            4'd2: w_seg_nx = 7'b0100100;
            4'd3: w_seg_nx = 7'b0110000;
            4'd4: w_seg_nx = 7'b0011001;
            4'd5: w_seg_nx = 7'b0010010;
            4'd6: w_seg_nx = 7'b0000010;
            4'd7: w_seg_nx = 7'b1111000;
            4'd8: w_seg_nx = 7'b0000000;
            4'd9: w_seg_nx = 7'b0010000;
            default: w_seg_nx = 7'b0111111;
        endcase
    end

    // Outputs are registered from next-state values so they align with cnt/sel.
    assign w_an_nx = (w_state_nx == ST_ON && digit_en[w_sel_nx] && !w_blank[w_sel_nx])
                     ? ~(4'b0001 << w_sel_nx) : 4'b1111;
    assign w_dp_nx = ~(w_shadow_dp_nx[w_sel_nx] && !w_blank[w_sel_nx]);
    assign w_frame_done_nx = (w_cnt_nx == c_CNT_LAST) && (w_sel_nx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_GUARD;
            r_cnt        <= '0;
            r_sel        <= 2'd0;
            r_staging    <= 16'h0000;
            r_staging_dp <= 4'h0;
            r_shadow     <= 16'h0000;
            r_shadow_dp  <= 4'h0;
            r_pending    <= 1'b0;
            r_an         <= 4'b1111;
            r_seg        <= 7'b1111111;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_sel        <= w_sel_nx;
            r_shadow     <= w_shadow_nx;
            r_shadow_dp  <= w_shadow_dp_nx;
            r_an         <= w_an_nx;
            r_seg        <= w_seg_nx;
            r_dp         <= w_dp_nx;
            r_frame_done <= w_frame_done_nx;
            if (load) begin
                r_staging    <= bcd_in;
                r_staging_dp <= dp_in;
            end
            if (w_boundary) begin
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign sel        = r_sel;
    assign frame_done = r_frame_done;
    assign pending    = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Self-checking bench for seg_scan_ctrl against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

    localparam int P = 10;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  sel;
    logic        frame_done;
    logic        pending;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.PRESCALAR(P), .GUARD(G)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .sel        (sel),
        .frame_done (frame_done),
        .pending    (pending)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: t counts cycles since reset release; slot and digit follow from t.
    int          t;
    logic [15:0] m_shadow, m_staging;
    logic [3:0]  m_shadow_dp, m_staging_dp;
    logic [3:0]  m_en_prev;
    logic        m_pending;
    logic [3:0]  cur_en;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0d: got %h expected %h", tag, t, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic blanked(input int d);
`ifdef LEADING_ZERO_BLANK_EN
        return (d != 0) && ((m_shadow >> (4 * d)) == 16'h0000);
`else
        return (d < 0);
`endif
    endfunction

    task automatic check_outputs();
        int          c, s;
        logic [3:0]  dg, ea;
        logic        bl;
        c  = t % P;
        s  = (t / P) % 4;
        check_eq("sel", 16'(sel), 16'(s));
        check_eq("pending", 16'(pending), 16'(m_pending));
        check_eq("frame_done", 16'(frame_done), 16'((c == P - 1) && (s == 3)));
        if (t == 0) begin
            check_eq("an_rst", 16'(an), 16'h000F);
            check_eq("seg_rst", 16'(seg), 16'h007F);
            check_eq("dp_rst", 16'(dp), 16'h0001);
        end else begin
            dg = 4'(m_shadow >> (4 * s));
            bl = blanked(s);
            ea = 4'hF;
            if (c >= G && m_en_prev[s] && !bl) ea = ~(4'b0001 << s);
            check_eq("an", 16'(an), 16'(ea));
            check_eq("seg", 16'(seg), 16'(seg_of(dg)));
            check_eq("dp", 16'(dp), 16'(!(m_shadow_dp[s] && !bl)));
        end
    endtask

    // Check the current cycle, drive inputs for the next edge, advance model.
    task automatic cycle(input logic ld, input logic [15:0] b, input logic [3:0] d);
        logic bnd;
        check_outputs();
        load     = ld;
        bcd_in   = b;
        dp_in    = d;
        digit_en = cur_en;
        bnd = ((t % P) == P - 1) && (((t / P) % 4) == 3);
        if (ld) begin
            m_staging    = b;
            m_staging_dp = d;
        end
        if (bnd) begin
            if (ld) begin
                m_shadow    = b;
                m_shadow_dp = d;
            end else if (m_pending) begin
                m_shadow    = m_staging;
                m_shadow_dp = m_staging_dp;
            end
            m_pending = 1'b0;
        end else if (ld) begin
            m_pending = 1'b1;
        end
        m_en_prev = cur_en;
        t++;
        @(negedge clk);
    endtask

    task automatic idle_to(input int target);
        while (t < target) cycle(1'b0, 16'h0000, 4'h0);
    endtask

    task automatic apply_reset(input int n);
        rst  = 1'b1;
        load = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check_eq("rst_an", 16'(an), 16'h000F);
            check_eq("rst_sel", 16'(sel), 16'h0000);
            check_eq("rst_pending", 16'(pending), 16'h0000);
            check_eq("rst_frame_done", 16'(frame_done), 16'h0000);
        end
        rst          = 1'b0;
        t            = 0;
        m_shadow     = 16'h0000;
        m_staging    = 16'h0000;
        m_shadow_dp  = 4'h0;
        m_staging_dp = 4'h0;
        m_pending    = 1'b0;
    endtask

    initial begin
        load      = 1'b0;
        bcd_in    = 16'h0000;
        dp_in     = 4'h0;
        cur_en    = 4'hF;
        digit_en  = cur_en;
        m_en_prev = cur_en;
        t         = 0;
        apply_reset(3);

        // First frame from reset: guard timing, sel stepping, frame_done at 39.
        idle_to(55);
        cycle(1'b1, 16'h1234, 4'b0001);
        check_eq("req033_pending", 16'(pending), 16'h0001);
        idle_to(83);
        check_eq("req033_seg", 16'(seg), 16'(7'b0011001));
        check_eq("req033_pending_clr", 16'(pending), 16'h0000);

        // Last load within a frame wins.
        idle_to(90);
        cycle(1'b1, 16'h1111, 4'h0);
        idle_to(100);
        cycle(1'b1, 16'h2222, 4'h0);
        idle_to(122);
        check_eq("req034_seg", 16'(seg), 16'(7'b0100100));

        // Load exactly on the frame boundary goes straight to shadow.
        idle_to(159);
        cycle(1'b1, 16'h0057, 4'b0100);
        check_eq("req035_pending", 16'(pending), 16'h0000);
        idle_to(183);
`ifdef LEADING_ZERO_BLANK_EN
        check_eq("req035_an", 16'(an), 16'h000F);
        check_eq("req035_dp", 16'(dp), 16'h0001);
`else
        check_eq("req035_an", 16'(an), 16'h000B);
        check_eq("req035_seg", 16'(seg), 16'(7'b1000000));
`endif

        // Disabled digit and out-of-range codes.
        cur_en = 4'b1011;
        idle_to(185);
        cycle(1'b1, 16'h00AF, 4'h0);
        idle_to(203);
        check_eq("req036_seg0", 16'(seg), 16'(7'b0111111));
        idle_to(213);
        check_eq("req036_seg1", 16'(seg), 16'(7'b0111111));
        idle_to(223);
        check_eq("req036_an2", 16'(an), 16'h000F);

        // Reset in an ON phase discards a pending value.
        cur_en = 4'hF;
        idle_to(245);
        cycle(1'b1, 16'h9999, 4'hF);
        idle_to(253);
        apply_reset(1);
        idle_to(45);

        // Randomized traffic, with boundary-coincident loads forced sometimes.
        for (int i = 0; i < 800; i++) begin
            logic ld;
            logic bnd;
            if ($urandom_range(0, 49) == 0) cur_en = 4'($urandom);
            bnd = ((t % P) == P - 1) && (((t / P) % 4) == 3);
            ld  = ($urandom_range(0, 14) == 0) || (bnd && $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0)
                cycle(ld, 16'($urandom) & 16'h0F0F, 4'($urandom));
            else
                cycle(ld, 16'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
